sprite_motion_seq: RTL and testbench

//   Frame-rate motion scheduler for the bouncing sprites of the VGA demo. On each VSync

---
 rtl/sprite_motion_seq.sv | 216 +++++++++++++++++++++
 tb/tb_sprite_motion_seq.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_seq.sv
// sprite_motion_seq: frame-rate motion scheduler for bouncing sprites.
// On each qualified VSync rising edge the FSM sweeps the sprite bank, one sprite per clock,
// stepping X/Y and reflecting direction at the screen limits. A host load port can
// place or redirect sprites while the sequencer is idle.
// Optional feature: define SPRITE_SPEED_EN to add a 2-bit per-sprite step size register
// loaded from LdSpd (speed 0 freezes the sprite). Without it every sprite steps by 1.
module sprite_motion_seq #(
  parameter int unsigned NSPR = 2,
  parameter int unsigned XMAX = 640,
  parameter int unsigned YMAX = 480,
  parameter int unsigned SIZE = 32,
  parameter int unsigned W    = 10
) (
  input  logic              CLK,
  input  logic              nReset,
  input  logic              VSync,
  input  logic              Run,
  input  logic              LdEn,
  input  logic [2:0]        LdIdx,
  input  logic [W-1:0]      LdX,
  input  logic [W-1:0]      LdY,
  input  logic [1:0]        LdDir,
  input  logic [1:0]        LdSpd,
  output logic              LdAck,
  output logic [NSPR*W-1:0] XPos,
  output logic [NSPR*W-1:0] YPos,
  output logic              Busy,
  output logic              Done,
  output logic              Overrun
);

  localparam int unsigned IdxW = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSPR - 1);
  localparam logic [3:0]      NsprCnt = 4'(NSPR);
  localparam logic [W:0]      XLim    = (W+1)'(XMAX - 1 - SIZE);
  localparam logic [W:0]      YLim    = (W+1)'(YMAX - 1 - SIZE);
  localparam logic [W:0]      Low     = (W+1)'(1);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic                       vsync_q;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       ack_q, ack_d;
  logic                       ovr_q, ovr_d;
  logic [NSPR-1:0][W-1:0]     x_q, x_d;
  logic [NSPR-1:0][W-1:0]     y_q, y_d;
  // Per sprite {ydir, xdir}, 1 = increasing.
  logic [NSPR-1:0][1:0]       dir_q, dir_d;

  logic                       upd;
  logic                       ld_ok;
  logic [IdxW-1:0]            ld_sel;
  logic [W:0]                 step;
  logic                       frozen;
  logic [W:0]                 x_res, y_res;

`ifdef SPRITE_SPEED_EN
  logic [NSPR-1:0][1:0]       spd_q, spd_d;
`else
  logic                       unused_ldspd;
  assign unused_ldspd = ^LdSpd;
`endif

  // One axis step. Result is {new_dir, new_pos}; compare is W+1 bits wide so p+s never wraps.
  function automatic logic [W:0] step_axis(input logic [W-1:0] p, input logic dir,
                                           input logic [W:0] s, input logic [W:0] lim);
    logic [W:0] pw;
    logic [W:0] res;
    pw = {1'b0, p};
    if (dir) begin
      if (pw + s >= lim) begin
        res = {1'b0, lim[W-1:0]};
      end else begin
        res    = pw + s;
        res[W] = 1'b1;
      end
    end else begin
      if (pw <= Low + s) begin
        res = {1'b1, Low[W-1:0]};
      end else begin
        res    = pw - s;
        res[W] = 1'b0;
      end
    end
    return res;
  endfunction

  assign upd    = VSync & ~vsync_q & Run;
  assign ld_sel = LdIdx[IdxW-1:0];
  assign ld_ok  = LdEn && (state_q == StIdle) && ({1'b0, LdIdx} < NsprCnt);

  // Step size and freeze flag for the sprite currently addressed by the sweep.
  always_comb begin
    step   = '0;
    frozen = 1'b0;
`ifdef SPRITE_SPEED_EN
    step[1:0] = spd_q[idx_q];
    frozen    = (spd_q[idx_q] == 2'd0);
`else
    step[0]   = 1'b1;
`endif
  end

  // Candidate new X/Y for the swept sprite, computed in parallel.
  always_comb begin
    x_res = step_axis(x_q[idx_q], dir_q[idx_q][0], step, XLim);
    y_res = step_axis(y_q[idx_q], dir_q[idx_q][1], step, YLim);
  end

  // Sequencer next state, bank updates and host load.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ack_d   = 1'b0;
    ovr_d   = ovr_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
`ifdef SPRITE_SPEED_EN
    spd_d   = spd_q;
`endif

    case (state_q)
      StIdle: begin
        if (upd) begin
          state_d = StSweep;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StSweep: begin
        if (!frozen) begin
          x_d[idx_q]      = x_res[W-1:0];
          y_d[idx_q]      = y_res[W-1:0];
          dir_d[idx_q][0] = x_res[W];
          dir_d[idx_q][1] = y_res[W];
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Frame edges that land on an active sweep are dropped but remembered.
    if (upd && (state_q != StIdle)) begin
      ovr_d = 1'b1;
    end

    // Loads only happen in idle, so they never collide with a sweep write.
    if (ld_ok) begin
      x_d[ld_sel]   = LdX;
      y_d[ld_sel]   = LdY;
      dir_d[ld_sel] = LdDir;
`ifdef SPRITE_SPEED_EN
      spd_d[ld_sel] = LdSpd;
`endif
      ack_d = 1'b1;
    end
  end

  // State and bank registers.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      vsync_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
      x_q     <= {NSPR{W'(1)}};
      y_q     <= {NSPR{W'(1)}};
      dir_q   <= '1;
`ifdef SPRITE_SPEED_EN
      spd_q   <= {NSPR{2'd1}};
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vsync_q <= VSync;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
`ifdef SPRITE_SPEED_EN
      spd_q   <= spd_d;
`endif
    end
  end

  assign XPos    = x_q;
  assign YPos    = y_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign LdAck   = ack_q;
  assign Overrun = ovr_q;

endmodule

// File: tb/tb_sprite_motion_seq.sv
// Self-checking bench for sprite_motion_seq with a frame-level behavioural model.
module tb_sprite_motion_seq;

  localparam int NSPR = 2;
  localparam int W    = 10;
  localparam int XLIM = 640 - 1 - 32;
  localparam int YLIM = 480 - 1 - 32;
  localparam int LOW  = 1;

  logic              CLK = 1'b0;
  logic              nReset;
  logic              VSync;
  logic              Run;
  logic              LdEn;
  logic [2:0]        LdIdx;
  logic [W-1:0]      LdX;
  logic [W-1:0]      LdY;
  logic [1:0]        LdDir;
  logic [1:0]        LdSpd;
  logic              LdAck;
  logic [NSPR*W-1:0] XPos;
  logic [NSPR*W-1:0] YPos;
  logic              Busy;
  logic              Done;
  logic              Overrun;

  int checks   = 0;
  int failures = 0;

  // Model state: positions, directions (1 = increasing), speeds.
  int mx[NSPR];
  int my[NSPR];
  int mdx[NSPR];
  int mdy[NSPR];
  int msp[NSPR];

  sprite_motion_seq #(.NSPR(NSPR)) dut (
    .CLK     (CLK),
    .nReset  (nReset),
    .VSync   (VSync),
    .Run     (Run),
    .LdEn    (LdEn),
    .LdIdx   (LdIdx),
    .LdX     (LdX),
    .LdY     (LdY),
    .LdDir   (LdDir),
    .LdSpd   (LdSpd),
    .LdAck   (LdAck),
    .XPos    (XPos),
    .YPos    (YPos),
    .Busy    (Busy),
    .Done    (Done),
    .Overrun (Overrun)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSPR; i++) begin
      mx[i] = 1; my[i] = 1; mdx[i] = 1; mdy[i] = 1; msp[i] = 1;
    end
  endtask

  task automatic model_load(input int i, input int x, input int y, input int d, input int s);
    mx[i] = x; my[i] = y; mdx[i] = d & 1; mdy[i] = (d >> 1) & 1; msp[i] = s;
  endtask

  // Move one coordinate by s toward its direction, bouncing off [LOW, lim].
  task automatic model_axis(inout int p, inout int d, input int s, input int lim);
    if (d == 1) begin
      if (p + s >= lim) begin p = lim; d = 0; end
      else p = p + s;
    end else begin
      if (p <= LOW + s) begin p = LOW; d = 1; end
      else p = p - s;
    end
  endtask

  task automatic model_frame();
    int s;
    for (int i = 0; i < NSPR; i++) begin
`ifdef SPRITE_SPEED_EN
      s = msp[i];
`else
      s = 1;
`endif
      if (s != 0) begin
        model_axis(mx[i], mdx[i], s, XLIM);
        model_axis(my[i], mdy[i], s, YLIM);
      end
    end
  endtask

  // One frame edge; lat = cycles from the update edge to Done, -1 if it never came.
  task automatic run_frame(output int lat);
    VSync = 1'b1;
    Run   = 1'b1;
    tick();
    VSync = 1'b0;
    lat   = -1;
    for (int k = 1; k <= 20; k++) begin
      if (Done === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic do_load(input int i, input int x, input int y, input int d, input int s,
                         output logic ack);
    LdEn  = 1'b1;
    LdIdx = 3'(i);
    LdX   = W'(x);
    LdY   = W'(y);
    LdDir = 2'(d);
    LdSpd = 2'(s);
    tick();
    ack  = LdAck;
    LdEn = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    VSync = 1'b0; Run = 1'b1; LdEn = 1'b0; LdIdx = '0; LdX = '0; LdY = '0;
    LdDir = '0; LdSpd = '0;
    model_reset();
    repeat (2) tick();
    nReset = 1'b1;
    tick();
    checks++;
    if ({Busy, Done, LdAck, Overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 0000", {Busy, Done, LdAck, Overrun});
    end
    for (int i = 0; i < NSPR; i++) begin
      checks++;
      if (XPos[i*W +: W] !== W'(mx[i]) || YPos[i*W +: W] !== W'(my[i])) begin
        failures++;
        $display("FAIL reset_pos[%0d]: got %0d,%0d want %0d,%0d", i, XPos[i*W +: W],
                 YPos[i*W +: W], mx[i], my[i]);
      end
    end
  endtask

  task automatic test_sweep_timing();
    logic exp_busy;
    logic exp_done;
    VSync = 1'b1;
    Run   = 1'b1;
    tick();
    VSync = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_busy = (k == 1 || k == 2);
      exp_done = (k == 3);
      checks++;
      if (Busy !== exp_busy || Done !== exp_done) begin
        failures++;
        $display("FAIL sweep_timing k=%0d: busy/done got %b%b want %b%b", k, Busy, Done,
                 exp_busy, exp_done);
      end
      if (k < 4) tick();
    end
    model_frame();
    for (int i = 0; i < NSPR; i++) begin
      checks++;
      if (XPos[i*W +: W] !== W'(mx[i]) || YPos[i*W +: W] !== W'(my[i])) begin
        failures++;
        $display("FAIL sweep_pos[%0d]: got %0d,%0d want %0d,%0d", i, XPos[i*W +: W],
                 YPos[i*W +: W], mx[i], my[i]);
      end
    end
  endtask

  task automatic test_bounce_x();
    logic ack;
    int   lat;
    do_load(0, 606, my[0], 3, 1, ack);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL bounce_x_ack: got %b want 1", ack);
    end
    model_load(0, 606, my[0], 3, 1);
    tick();
    for (int f = 0; f < 2; f++) begin
      run_frame(lat);
      model_frame();
      checks++;
      if (lat != NSPR + 1 || XPos[0 +: W] !== W'(mx[0])) begin
        failures++;
        $display("FAIL bounce_x f=%0d: lat %0d x %0d want lat %0d x %0d", f, lat,
                 XPos[0 +: W], NSPR + 1, mx[0]);
      end
    end
  endtask

  task automatic test_bounce_y();
    logic ack;
    int   lat;
    do_load(1, mx[1], 2, 0, 1, ack);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL bounce_y_ack: got %b want 1", ack);
    end
    model_load(1, mx[1], 2, 0, 1);
    tick();
    for (int f = 0; f < 2; f++) begin
      run_frame(lat);
      model_frame();
      checks++;
      if (lat != NSPR + 1 || YPos[W +: W] !== W'(my[1]) || XPos[W +: W] !== W'(mx[1])) begin
        failures++;
        $display("FAIL bounce_y f=%0d: lat %0d pos %0d,%0d want %0d,%0d", f, lat,
                 XPos[W +: W], YPos[W +: W], mx[1], my[1]);
      end
    end
  endtask

  task automatic test_load_reject();
    logic ack;
    VSync = 1'b1;
    Run   = 1'b1;
    tick();
    VSync = 1'b0;
    // Now sweeping: the load must be ignored.
    do_load(0, 300, 300, 0, 1, ack);
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL reject_busy_ack: got %b want 0", ack);
    end
    repeat (4) tick();
    model_frame();
    for (int i = 0; i < NSPR; i++) begin
      checks++;
      if (XPos[i*W +: W] !== W'(mx[i]) || YPos[i*W +: W] !== W'(my[i])) begin
        failures++;
        $display("FAIL reject_busy_pos[%0d]: got %0d,%0d want %0d,%0d", i, XPos[i*W +: W],
                 YPos[i*W +: W], mx[i], my[i]);
      end
    end
    do_load(5, 100, 100, 0, 1, ack);
    tick();
    checks++;
    if (ack !== 1'b0 || LdAck !== 1'b0) begin
      failures++;
      $display("FAIL reject_idx_ack: got %b%b want 00", ack, LdAck);
    end
    for (int i = 0; i < NSPR; i++) begin
      checks++;
      if (XPos[i*W +: W] !== W'(mx[i]) || YPos[i*W +: W] !== W'(my[i])) begin
        failures++;
        $display("FAIL reject_idx_pos[%0d]: got %0d,%0d want %0d,%0d", i, XPos[i*W +: W],
                 YPos[i*W +: W], mx[i], my[i]);
      end
    end
  endtask

  task automatic test_load_with_upd();
    logic ack;
    LdEn = 1'b1; LdIdx = 3'd1; LdX = W'(10); LdY = W'(20); LdDir = 2'b01; LdSpd = 2'd1;
    VSync = 1'b1;
    Run   = 1'b1;
    tick();
    ack   = LdAck;
    LdEn  = 1'b0;
    VSync = 1'b0;
    model_load(1, 10, 20, 1, 1);
    checks++;
    if (ack !== 1'b1 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL load_with_upd_start: ack/busy got %b%b want 11", ack, Busy);
    end
    repeat (4) tick();
    model_frame();
    checks++;
    if (XPos[W +: W] !== W'(mx[1]) || YPos[W +: W] !== W'(my[1])) begin
      failures++;
      $display("FAIL load_with_upd_pos: got %0d,%0d want %0d,%0d", XPos[W +: W],
               YPos[W +: W], mx[1], my[1]);
    end
  endtask

  task automatic test_random();
    logic ack;
    int   lat;
    int   op;
    int   idx;
    int   x;
    int   y;
    int   d;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        idx = $urandom_range(0, 7);
        x   = $urandom_range(0, 1023);
        y   = $urandom_range(0, 1023);
        d   = $urandom_range(0, 3);
        do_load(idx, x, y, d, 1, ack);
        checks++;
        if (ack !== (idx < NSPR)) begin
          failures++;
          $display("FAIL rand_load_ack n=%0d idx=%0d: got %b want %b", n, idx, ack,
                   (idx < NSPR));
        end
        if (idx < NSPR) model_load(idx, x, y, d, 1);
        tick();
      end else if (op == 1) begin
        VSync = 1'b1;
        Run   = 1'b0;
        tick();
        VSync = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b0) begin
          failures++;
          $display("FAIL rand_norun n=%0d: busy got %b want 0", n, Busy);
        end
        Run = 1'b1;
        tick();
      end else begin
        run_frame(lat);
        model_frame();
        checks++;
        if (lat != NSPR + 1) begin
          failures++;
          $display("FAIL rand_lat n=%0d: got %0d want %0d", n, lat, NSPR + 1);
        end
      end
      for (int i = 0; i < NSPR; i++) begin
        checks++;
        if (XPos[i*W +: W] !== W'(mx[i]) || YPos[i*W +: W] !== W'(my[i])) begin
          failures++;
          $display("FAIL rand_pos n=%0d [%0d]: got %0d,%0d want %0d,%0d", n, i,
                   XPos[i*W +: W], YPos[i*W +: W], mx[i], my[i]);
        end
      end
    end
  endtask

  task automatic test_overrun_and_midreset();
    int lat;
    checks++;
    if (Overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_pre: got %b want 0", Overrun);
    end
    VSync = 1'b1; Run = 1'b1;
    tick();
    VSync = 1'b0;
    tick();
    VSync = 1'b1;
    tick();
    VSync = 1'b0;
    checks++;
    if (Overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: got %b want 1", Overrun);
    end
    repeat (3) tick();
    model_frame();
    for (int i = 0; i < NSPR; i++) begin
      checks++;
      if (XPos[i*W +: W] !== W'(mx[i]) || YPos[i*W +: W] !== W'(my[i])) begin
        failures++;
        $display("FAIL overrun_pos[%0d]: got %0d,%0d want %0d,%0d", i, XPos[i*W +: W],
                 YPos[i*W +: W], mx[i], my[i]);
      end
    end
    run_frame(lat);
    model_frame();
    checks++;
    if (Overrun !== 1'b1 || lat != NSPR + 1) begin
      failures++;
      $display("FAIL overrun_sticky: ovr %b lat %0d want 1 %0d", Overrun, lat, NSPR + 1);
    end
    // Reset in the middle of a sweep.
    VSync = 1'b1;
    tick();
    VSync = 1'b0;
    tick();
    nReset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({Busy, Done, Overrun} !== 3'b000 || XPos[0 +: W] !== W'(mx[0]) ||
        YPos[W +: W] !== W'(my[1])) begin
      failures++;
      $display("FAIL midreset: flags %b x0 %0d y1 %0d want 000 %0d %0d", {Busy, Done, Overrun},
               XPos[0 +: W], YPos[W +: W], mx[0], my[1]);
    end
    tick();
    nReset = 1'b1;
    tick();
    run_frame(lat);
    model_frame();
    for (int i = 0; i < NSPR; i++) begin
      checks++;
      if (XPos[i*W +: W] !== W'(mx[i]) || YPos[i*W +: W] !== W'(my[i])) begin
        failures++;
        $display("FAIL postreset_pos[%0d]: got %0d,%0d want %0d,%0d", i, XPos[i*W +: W],
                 YPos[i*W +: W], mx[i], my[i]);
      end
    end
  endtask

`ifdef SPRITE_SPEED_EN
  task automatic test_speed();
    logic ack;
    int   lat;
    do_load(0, 605, my[0], 3, 3, ack);
    model_load(0, 605, my[0], 3, 3);
    tick();
    run_frame(lat);
    model_frame();
    checks++;
    if (ack !== 1'b1 || XPos[0 +: W] !== W'(mx[0])) begin
      failures++;
      $display("FAIL speed3: ack %b x %0d want 1 %0d", ack, XPos[0 +: W], mx[0]);
    end
    do_load(0, 400, 200, 1, 0, ack);
    model_load(0, 400, 200, 1, 0);
    tick();
    for (int f = 0; f < 3; f++) begin
      run_frame(lat);
      model_frame();
      checks++;
      if (XPos[0 +: W] !== W'(mx[0]) || YPos[0 +: W] !== W'(my[0])) begin
        failures++;
        $display("FAIL speed0 f=%0d: got %0d,%0d want %0d,%0d", f, XPos[0 +: W],
                 YPos[0 +: W], mx[0], my[0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep_timing();
    test_bounce_x();
    test_bounce_y();
    test_load_reject();
    test_load_with_upd();
    test_random();
`ifdef SPRITE_SPEED_EN
    test_speed();
`endif
    test_overrun_and_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
